// File: rtl/sram_ctrl_pkg.sv
// Shared types and width helpers for the asynchronous SRAM controller.
// States and derived geometry are used by sram_ctrl and sram_beat_seq.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD,
    ST_RSP
  } state_e;

  // Narrowest counter the wait-state and beat-index registers may use.
  localparam int WAIT_W_MIN = 1;

  function automatic int calc_beats(input int bus_dw, input int sram_dw);
    return bus_dw / sram_dw;
  endfunction

  function automatic int calc_lanes(input int sram_dw);
    return sram_dw / 8;
  endfunction

  function automatic int calc_cmd_aw(input int sram_aw, input int bus_dw, input int sram_dw);
    return sram_aw - $clog2(bus_dw / sram_dw);
  endfunction

  // Bits needed to hold the values 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? WAIT_W_MIN : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_beat_seq.sv
// Finds the lowest beat at or after a start index that must run on the SRAM.
// Write beats with an all-zero lane mask are skipped; reads run every beat.
module sram_beat_seq
  import sram_ctrl_pkg::*;
#(
  parameter  int BEATS = 2,
  parameter  int SL    = 2,
  localparam int BW    = cnt_width(BEATS)
) (
  input  logic [BEATS*SL-1:0] i_mask,
  input  logic                i_write,
  input  logic [BW-1:0]       i_start,
  input  logic                i_incl,
  output logic [BW-1:0]       o_beat,
  output logic                o_none
);

  // Descending scan so the lowest qualifying beat is the one left standing.
  always_comb begin
    o_beat = '0;
    o_none = 1'b1;
    for (int b = BEATS - 1; b >= 0; b--) begin
      if (((b > int'(i_start)) || (i_incl && (b == int'(i_start)))) &&
          (!i_write || (|i_mask[b*SL +: SL]))) begin
        o_beat = BW'(b);
        o_none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Bus-word to multi-beat asynchronous SRAM controller with programmable wait states.
// Optional SRAM_LEDS_EN adds the sram_leds debug register fed by lane-0 writes.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter  int BUS_DW      = 32,
  parameter  int SRAM_DW     = 16,
  parameter  int SRAM_AW     = 18,
  parameter  int WAIT_CYCLES = 2,
  localparam int BEATS       = calc_beats(BUS_DW, SRAM_DW),
  localparam int SL          = calc_lanes(SRAM_DW),
  localparam int CMD_AW      = calc_cmd_aw(SRAM_AW, BUS_DW, SRAM_DW),
  localparam int BW          = cnt_width(BEATS),
  localparam int WW          = cnt_width(WAIT_CYCLES)
) (
  input  logic                io_mainClk,
  input  logic                io_asyncReset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [CMD_AW-1:0]   cmd_addr,
  input  logic [BUS_DW-1:0]   cmd_wdata,
  input  logic [BUS_DW/8-1:0] cmd_mask,
  output logic                rsp_valid,
  output logic [BUS_DW-1:0]   rsp_rdata,
  output logic [SRAM_AW-1:0]  sram_addr,
  input  logic [SRAM_DW-1:0]  sram_dat_read,
  output logic [SRAM_DW-1:0]  sram_dat_write,
  output logic                sram_dat_writeEnable,
  output logic                sram_cs_n,
  output logic                sram_we_n,
  output logic                sram_oe_n,
  output logic [SL-1:0]       sram_be_n
`ifdef SRAM_LEDS_EN
  ,
  output logic [7:0]          sram_leds
`endif
);

  // state  | meaning
  // IDLE   | cmd_ready high, strobes inactive, waiting for a command
  // SETUP  | address/lanes (and write data) presented, cs_n low
  // ACCESS | strobe active for WAIT_CYCLES cycles; read data sampled on the last
  // HOLD   | write only: we_n released while address/data/cs stay stable
  // RSP    | rsp_valid pulse with the assembled read word

  localparam int LOG_B = $clog2(BEATS);

  state_e                r_state;
  logic                  r_cmd_ready;
  logic                  r_rsp_valid;
  logic [BUS_DW-1:0]     r_rdata;
  logic [SRAM_AW-1:0]    r_sram_addr;
  logic [SRAM_DW-1:0]    r_dat_write;
  logic                  r_de;
  logic                  r_cs_n;
  logic                  r_we_n;
  logic                  r_oe_n;
  logic [SL-1:0]         r_be_n;
  logic                  r_write;
  logic [CMD_AW-1:0]     r_addr;
  logic [BUS_DW-1:0]     r_wdata;
  logic [BUS_DW/8-1:0]   r_mask;
  logic [BW-1:0]         r_beat;
  logic [WW-1:0]         r_wait;
`ifdef SRAM_LEDS_EN
  logic [7:0]            r_leds;
`endif

  logic                  w_accept;
  logic                  w_first_none;
  logic [BW-1:0]         w_first_beat;
  logic                  w_next_none;
  logic [BW-1:0]         w_next_beat;
  logic                  w_go_setup;
  logic                  w_in_idle;
  logic                  w_sel_write;
  logic [BW-1:0]         w_sel_beat;
  logic [CMD_AW-1:0]     w_sel_addr;
  logic [BUS_DW-1:0]     w_sel_wdata;
  logic [BUS_DW/8-1:0]   w_sel_mask;
  logic [SRAM_AW-1:0]    w_sel_saddr;

  sram_beat_seq #(.BEATS(BEATS), .SL(SL)) u_first (
    .i_mask  (cmd_mask),
    .i_write (cmd_write),
    .i_start ('0),
    .i_incl  (1'b1),
    .o_beat  (w_first_beat),
    .o_none  (w_first_none)
  );

  sram_beat_seq #(.BEATS(BEATS), .SL(SL)) u_next (
    .i_mask  (r_mask),
    .i_write (r_write),
    .i_start (r_beat),
    .i_incl  (1'b0),
    .o_beat  (w_next_beat),
    .o_none  (w_next_none)
  );

  assign w_in_idle = (r_state == ST_IDLE);
  assign w_accept  = w_in_idle && cmd_valid && r_cmd_ready;

  // First beat comes straight from the command; later beats from the latched copy.
  assign w_sel_write = w_in_idle ? cmd_write    : r_write;
  assign w_sel_beat  = w_in_idle ? w_first_beat : w_next_beat;
  assign w_sel_addr  = w_in_idle ? cmd_addr     : r_addr;
  assign w_sel_wdata = w_in_idle ? cmd_wdata    : r_wdata;
  assign w_sel_mask  = w_in_idle ? cmd_mask     : r_mask;
  assign w_sel_saddr = (SRAM_AW'(w_sel_addr) << LOG_B) | SRAM_AW'(w_sel_beat);

  assign w_go_setup = (w_accept && !w_first_none) ||
                      ((r_state == ST_ACCESS) && (r_wait == '0) && !r_write && !w_next_none) ||
                      ((r_state == ST_HOLD) && !w_next_none);

  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_sram_addr <= '0;
      r_dat_write <= '0;
      r_de        <= 1'b0;
      r_cs_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_be_n      <= '1;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mask      <= '0;
      r_beat      <= '0;
      r_wait      <= '0;
`ifdef SRAM_LEDS_EN
      r_leds      <= '0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= !w_accept;
          if (w_accept) begin
            r_write <= cmd_write;
            r_addr  <= cmd_addr;
            r_wdata <= cmd_wdata;
            r_mask  <= cmd_mask;
`ifdef SRAM_LEDS_EN
            if (cmd_write && cmd_mask[0]) r_leds <= cmd_wdata[7:0];
`endif
          end
        end
        ST_SETUP: begin
          r_state <= ST_ACCESS;
          r_wait  <= WW'(WAIT_CYCLES - 1);
          if (r_write) r_we_n <= 1'b0;
        end
        ST_ACCESS: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - 1'b1;
          end else if (r_write) begin
            r_state <= ST_HOLD;
            r_we_n  <= 1'b1;
          end else begin
            r_rdata[r_beat*SRAM_DW +: SRAM_DW] <= sram_dat_read;
            if (w_next_none) begin
              r_state     <= ST_RSP;
              r_rsp_valid <= 1'b1;
              r_cs_n      <= 1'b1;
              r_oe_n      <= 1'b1;
              r_be_n      <= '1;
            end
          end
        end
        ST_HOLD: begin
          if (w_next_none) begin
            r_state <= ST_IDLE;
            r_cs_n  <= 1'b1;
            r_de    <= 1'b0;
            r_be_n  <= '1;
          end
        end
        ST_RSP:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      // Shared beat launch; overrides the per-state updates above.
      if (w_go_setup) begin
        r_state     <= ST_SETUP;
        r_beat      <= w_sel_beat;
        r_sram_addr <= w_sel_saddr;
        r_cs_n      <= 1'b0;
        if (w_sel_write) begin
          r_de        <= 1'b1;
          r_we_n      <= 1'b1;
          r_oe_n      <= 1'b1;
          r_dat_write <= w_sel_wdata[w_sel_beat*SRAM_DW +: SRAM_DW];
          r_be_n      <= ~w_sel_mask[w_sel_beat*SL +: SL];
        end else begin
          r_de        <= 1'b0;
          r_oe_n      <= 1'b0;
          r_be_n      <= '0;
        end
      end
    end
  end

  assign cmd_ready            = r_cmd_ready;
  assign rsp_valid            = r_rsp_valid;
  assign rsp_rdata            = r_rdata;
  assign sram_addr            = r_sram_addr;
  assign sram_dat_write       = r_dat_write;
  assign sram_dat_writeEnable = r_de;
  assign sram_cs_n            = r_cs_n;
  assign sram_we_n            = r_we_n;
  assign sram_oe_n            = r_oe_n;
  assign sram_be_n            = r_be_n;
`ifdef SRAM_LEDS_EN
  assign sram_leds            = r_leds;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: behavioural SRAM on the pins, a command table,
// a read-data scoreboard queue and hand sequences for reset corner cases.
`timescale 1ns/1ps
module tb_sram_ctrl;

  localparam int BUS_DW      = 32;
  localparam int SRAM_DW     = 16;
  localparam int SRAM_AW     = 18;
  localparam int WAIT_CYCLES = 2;
  localparam int CMD_AW      = 17;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 cmd_valid, cmd_ready, cmd_write;
  logic [CMD_AW-1:0]    cmd_addr;
  logic [BUS_DW-1:0]    cmd_wdata;
  logic [3:0]           cmd_mask;
  logic                 rsp_valid;
  logic [BUS_DW-1:0]    rsp_rdata;
  logic [SRAM_AW-1:0]   sram_addr;
  logic [SRAM_DW-1:0]   sram_dat_read, sram_dat_write;
  logic                 sram_dat_writeEnable, sram_cs_n, sram_we_n, sram_oe_n;
  logic [1:0]           sram_be_n;
`ifdef SRAM_LEDS_EN
  logic [7:0]           sram_leds;
`endif

  sram_ctrl #(
    .BUS_DW(BUS_DW), .SRAM_DW(SRAM_DW), .SRAM_AW(SRAM_AW), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .io_mainClk           (clk),
    .io_asyncReset_n      (rst_n),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_write            (cmd_write),
    .cmd_addr             (cmd_addr),
    .cmd_wdata            (cmd_wdata),
    .cmd_mask             (cmd_mask),
    .rsp_valid            (rsp_valid),
    .rsp_rdata            (rsp_rdata),
    .sram_addr            (sram_addr),
    .sram_dat_read        (sram_dat_read),
    .sram_dat_write       (sram_dat_write),
    .sram_dat_writeEnable (sram_dat_writeEnable),
    .sram_cs_n            (sram_cs_n),
    .sram_we_n            (sram_we_n),
    .sram_oe_n            (sram_oe_n),
    .sram_be_n            (sram_be_n)
`ifdef SRAM_LEDS_EN
    ,
    .sram_leds            (sram_leds)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q [$];

  logic [15:0] mem [int];
  int n_cs, n_oe, n_we;

  function automatic logic [15:0] mem_rd(input int a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  // Behavioural SRAM plus strobe-activity counters, evaluated mid-cycle.
  always @(negedge clk) begin
    logic [15:0] w;
    if (!sram_cs_n) n_cs++;
    if (!sram_cs_n && !sram_oe_n) n_oe++;
    if (!sram_cs_n && !sram_we_n) begin
      n_we++;
      if (sram_dat_writeEnable) begin
        w = mem_rd(int'(sram_addr));
        if (!sram_be_n[0]) w[7:0]  = sram_dat_write[7:0];
        if (!sram_be_n[1]) w[15:8] = sram_dat_write[15:8];
        mem[int'(sram_addr)] = w;
      end
    end
    sram_dat_read = (!sram_cs_n && !sram_oe_n) ? mem_rd(int'(sram_addr)) : 16'h0000;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name, output bit ok);
    int k;
    @(negedge clk);
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    ok = cmd_ready;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s: cmd_ready never rose within 50 cycles", name);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_cs;
    int          exp_stb;
  } vec_t;

  vec_t vecs[13];

  task automatic run_cmd(input string name, input vec_t v);
    bit ok, done;
    int lat;
    logic [31:0] e;
    wait_ready({name, "_ready"}, ok);
    if (!ok) return;
    n_cs = 0; n_oe = 0; n_we = 0;
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_mask  = v.mask;
    if (!v.wr) exp_q.push_back(v.exp_rdata);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_wdata = '0;
    cmd_mask  = '0;
    done = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 100 && !done; k++) begin
      @(posedge clk);
      #1;
      if (!v.wr && rsp_valid) begin
        done = 1'b1;
        lat  = k;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL %s_rdata: response with empty scoreboard", name);
        end else begin
          e = exp_q.pop_front();
          chk({name, "_rdata"}, 64'(rsp_rdata), 64'(e));
        end
      end
      if (v.wr && cmd_ready) begin
        done = 1'b1;
        lat  = k;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no completion within 100 cycles", name);
      return;
    end
    chk({name, "_latency"}, 64'(lat), 64'(v.exp_lat));
    chk({name, "_cs_cycles"}, 64'(n_cs), 64'(v.exp_cs));
    chk({name, "_strobe_cycles"}, 64'(v.wr ? n_we : n_oe), 64'(v.exp_stb));
    if (!v.wr) begin
      @(posedge clk);
      #1;
      chk({name, "_rsp_pulse"}, 64'(rsp_valid), 64'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    vec_t v;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_mask = '0;
    sram_dat_read = '0;
    mem[32'h2468] = 16'hBEEF;
    mem[32'h2469] = 16'hDEAD;

    //            wr addr      wdata         mask  exp_rdata     lat cs stb
    vecs[0]  = '{1'b0, 17'h01234, 32'h00000000, 4'h0, 32'hDEADBEEF, 6, 6, 6};
    vecs[1]  = '{1'b1, 17'h01234, 32'hCAFEF00D, 4'hF, 32'h00000000, 9, 8, 4};
    vecs[2]  = '{1'b0, 17'h01234, 32'h00000000, 4'h0, 32'hCAFEF00D, 6, 6, 6};
    vecs[3]  = '{1'b1, 17'h01234, 32'h12345678, 4'h4, 32'h00000000, 5, 4, 2};
    vecs[4]  = '{1'b0, 17'h01234, 32'h00000000, 4'h0, 32'hCA34F00D, 6, 6, 6};
    vecs[5]  = '{1'b1, 17'h01234, 32'hFFFFFFFF, 4'h0, 32'h00000000, 1, 0, 0};
    vecs[6]  = '{1'b0, 17'h01234, 32'h00000000, 4'h0, 32'hCA34F00D, 6, 6, 6};
    vecs[7]  = '{1'b1, 17'h00010, 32'hA1B2C3D4, 4'h9, 32'h00000000, 9, 8, 4};
    vecs[8]  = '{1'b0, 17'h00010, 32'h00000000, 4'h0, 32'hA10000D4, 6, 6, 6};
    vecs[9]  = '{1'b1, 17'h1FFFF, 32'h55667788, 4'h3, 32'h00000000, 5, 4, 2};
    vecs[10] = '{1'b0, 17'h1FFFF, 32'h00000000, 4'h0, 32'h00007788, 6, 6, 6};
    vecs[11] = '{1'b1, 17'h01234, 32'h0000AB00, 4'h2, 32'h00000000, 5, 4, 2};
    vecs[12] = '{1'b0, 17'h01234, 32'h00000000, 4'h0, 32'hCA34AB0D, 6, 6, 6};

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_strobes", 64'({sram_cs_n, sram_we_n, sram_oe_n}), 64'(3'b111));
    chk("rst_be_n", 64'(sram_be_n), 64'(2'b11));
    chk("rst_write_enable", 64'(sram_dat_writeEnable), 64'(0));
    chk("rst_sram_addr", 64'(sram_addr), 64'(0));
    chk("rst_dat_write", 64'(sram_dat_write), 64'(0));
`ifdef SRAM_LEDS_EN
    chk("rst_leds", 64'(sram_leds), 64'(0));
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 64'(cmd_ready), 64'(1));

    for (int i = 0; i < 13; i++) run_cmd($sformatf("v%0d", i), vecs[i]);

    // Reset asserted while a write strobe is active.
    wait_ready("midrst_ready", ok);
    if (ok) begin
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 17'h00100;
      cmd_wdata = 32'h11112222; cmd_mask = 4'hF;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_we_active", 64'(sram_we_n), 64'(0));
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_we_n", 64'(sram_we_n), 64'(1));
      chk("midrst_cs_n", 64'(sram_cs_n), 64'(1));
      chk("midrst_write_enable", 64'(sram_dat_writeEnable), 64'(0));
      chk("midrst_cmd_ready", 64'(cmd_ready), 64'(0));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_ready_after", 64'(cmd_ready), 64'(1));
      run_cmd("post_rst_read", vecs[12]);
    end

`ifdef SRAM_LEDS_EN
    v = '{1'b1, 17'h00008, 32'h000000A5, 4'h1, 32'h00000000, 5, 4, 2};
    run_cmd("leds_write", v);
    chk("leds_after_write", 64'(sram_leds), 64'(8'hA5));
    run_cmd("leds_read", vecs[12]);
    chk("leds_after_read", 64'(sram_leds), 64'(8'hA5));
`else
    v = vecs[5];
    run_cmd("final_zero_mask", v);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Parametrised external asynchronous SRAM controller; next generation of the fixed 16-bit/18-bit SRAM port on the Murax BlackIce top level.
- Converts single bus-word read/write commands (valid/ready) into one or more SRAM beats, with programmable wait states and per-lane byte enables.
- Sits between the Murax SoC memory bus and the SB_IO tristate data pins.

Parameters:
- BUS_DW, 32, bus data width; integer multiple of SRAM_DW.
- SRAM_DW, 16, SRAM data width; multiple of 8.
- SRAM_AW, 18, SRAM address width, in SRAM words.
- WAIT_CYCLES, 2, cycles the strobe (we_n/oe_n) is held active per beat; legal range ≥1.
- Derived constants: BEATS=BUS_DW/SRAM_DW; SL=SRAM_DW/8; CMD_AW=SRAM_AW-$clog2(BEATS).

Ports:
- io_mainClk  in  1  clock.
- io_asyncReset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when valid&&ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  CMD_AW  bus-word address.
- cmd_wdata  in  BUS_DW  write data.
- cmd_mask  in  BUS_DW/8  byte write enables.
- rsp_valid  out  1  one-cycle read-data strobe.
- rsp_rdata  out  BUS_DW  read data.
- sram_addr  out  SRAM_AW  SRAM address.
- sram_dat_read  in  SRAM_DW  data from the pad.
- sram_dat_write  out  SRAM_DW  data to the pad.
- sram_dat_writeEnable  out  1  pad output enable.
- sram_cs_n, sram_we_n, sram_oe_n  out  1 each  active-low SRAM strobes.
- sram_be_n  out  SL  active-low byte lanes (lane0=LB, lane1=UB).

Behaviour:
- Reset values:
  - cmd_ready=0, rsp_valid=0, rsp_rdata=0.
  - sram_cs_n=sram_we_n=sram_oe_n=1, sram_be_n=all 1.
  - sram_dat_writeEnable=0, sram_addr=0, sram_dat_write=0.
  - FSM=IDLE.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, HOLD, RSP.
  - IDLE:
    - cmd_ready=1; all strobes inactive.
    - On acceptance, latch the command, beat=first beat to execute, then go to SETUP.
  - SETUP (1 cycle):
    - cs_n=0; sram_addr={addr,beat}.
    - Read: oe_n=0, be_n=0.
    - Write: writeEnable=1, dat_write=wdata slice, be_n=~mask slice, we_n=1.
  - ACCESS (WAIT_CYCLES cycles, wait counter):
    - Read: oe_n stays 0; dat_read is captured into rdata slice on the last ACCESS cycle's edge.
    - Write: we_n=0.
  - HOLD (writes only, 1 cycle): we_n=1; data, address and cs held.
  - After the last ACCESS (read) or HOLD (write):
    - If more beats remain, go to SETUP with the next beat.
    - Otherwise, read goes to RSP and write goes to IDLE.
  - RSP (1 cycle): rsp_valid=1, rsp_rdata valid; cs_n=1; next state IDLE.
- Beat order: beat0 = SRAM word addressed {addr,0} = bus bits [SRAM_DW-1:0], ascending (little-endian).
- Write beats whose mask slice is all zero are skipped entirely (no SETUP/ACCESS/HOLD).
  - An all-zero cmd_mask write is accepted and completes in 1 cycle (IDLE→IDLE, no SRAM activity).
- Latency, with acceptance edge = 0:
  - Read: rsp_valid rises at edge BEATS*(1+WAIT_CYCLES).
  - Write: cmd_ready returns at edge n*(2+WAIT_CYCLES)+1, with n = number of non-skipped beats.
- Reads always execute all beats with all lanes enabled.
- Unread rdata slices are left unchanged only for skipped write beats; reads overwrite all slices.
- cmd_* inputs are ignored outside IDLE; there is no back-pressure on rsp.
- Reset mid-operation: immediate return to reset values; the strobes deassert asynchronously on reset assertion.

Optional Feature:
- SRAM_LEDS_EN:
  - Defined: adds output sram_leds[7:0], reset 0, updated to cmd_wdata[7:0] on every accepted write with cmd_mask[0]=1. This mirrors the legacy debug LED bank.
  - Undefined: the port and its register do not exist.

Decomposition:
- Package sram_ctrl_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, HOLD, RSP);
  - derived BEATS/SL/CMD_AW helper functions;
  - WAIT counter width constant.
- Optional sub-module sram_beat_seq: computes the next non-skipped beat index and the last-beat flag from the mask and current beat.

Test Plan:
- Read, BUS_DW=32, WAIT=2, addr 0x1234, SRAM words 0x2468=0xBEEF and 0x2469=0xDEAD → two SETUP+2×ACCESS sequences, oe_n low for 6 cycles, rsp_valid at edge 6 with 0xDEADBEEF.
- Write 0xCAFEF00D, mask 0xF → beats at 0x2468/0x2469, data 0xF00D then 0xCAFE, we_n low 2 cycles each, be_n=00, cmd_ready back at edge 9.
- Write, mask 0x4 → only beat1 executes, be_n=10 (LB active... lane0 only, UB off), data 0xCAFE, cmd_ready at edge 5.
- Write, mask 0x0 → no cs_n activity, cmd_ready high again next cycle.
- Reset asserted during the ACCESS of a write → we_n and cs_n high asynchronously, writeEnable=0; after release, FSM is IDLE and cmd_ready=1.
- SRAM_LEDS_EN defined, write 0x000000A5 mask 0x1 → sram_leds=0xA5 one cycle after acceptance; a read leaves it unchanged.
